pool_window_sequencer: RTL and testbench
========================================

Name: pool_window_sequencer

Overview:
- Sequences one column of the pooling datapath: per-column register file plus compare unit (max or average).
- Performs 2x2, stride-2 pooling over a feature map that the systolic array streams in raster order, one pixel per in_valid beat.
- Generates register-file addresses, write strobes, the input-mux select, and pooled-output valid/done.
- Its outputs drive column 0; the existing per-column delay registers forward them to the other columns.

Parameters:
- ADDR_W, 4: register-file address width. Max feature-map width is 2*2^ADDR_W.
- DIM_W, 8: width of the runtime feature-map dimension inputs.

Ports:
- clk  input  1  clock
- nrst  input  1  asynchronous active-low reset
- start  input  1  start a pooling pass; sampled in IDLE only
- fmap_w  input  DIM_W  feature-map width in pixels; latched on accepted start
- fmap_h  input  DIM_W  feature-map height in pixels; latched on accepted start
- in_valid  input  1  systolic-array output pixel valid this cycle
- mux_en  output  1  1 = compare-unit input taken from systolic array
- wr_ctrl1  output  1  write systolic pixel to reg file at adrs_in1
- wr_ctrl2  output  1  write pooled result to reg file at adrs_in2
- adrs_in1  output  ADDR_W  write address, port 1
- adrs_in2  output  ADDR_W  write address, port 2
- adrs_out  output  ADDR_W  read address
- pool_valid  output  1  pooled result on compare output is final this cycle
- pool_done  output  1  one-cycle pulse, pass complete
- busy  output  1  high in RUN and DONE
- cfg_err  output  1  one-cycle pulse, start rejected
- stall_cnt  output  16  see Optional Feature

Behaviour:
- Reset: state=IDLE, row/col counters 0, latched dims 0, stall_cnt 0. All outputs 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on start with 2<=fmap_w<=2*2^ADDR_W and fmap_h>=2. Latch dims; row=0, col=0.
- Start rejected: any other start in IDLE pulses cfg_err for the cycle after start and stays in IDLE.
- Start while busy: ignored, no error.
- Counter advance (RUN): col advances only on in_valid beats. At col==fmap_w-1, col wraps to 0 and row increments.
- RUN -> DONE: on the beat where row==fmap_h-1 and col==fmap_w-1.
- DONE: pool_done=1 for exactly one cycle, then IDLE. busy drops in IDLE.
- Control decode: Mealy, combinational from registered row/col gated by in_valid, so the reg file writes on the same clock edge as the beat. h=col>>1 (ADDR_W bits).
- Beat at row even, col even: wr_ctrl1=1, adrs_in1=h, mux_en=1.
- Beat at row even/col odd or row odd/col even: mux_en=1, adrs_out=h, wr_ctrl2=1, adrs_in2=h.
- Beat at row odd, col odd: mux_en=1, adrs_out=h, wr_ctrl2=0, pool_valid=1.
- Dropped pixels: odd fmap_w drops the last column, odd fmap_h drops the last row (floor semantics). Beats on dropped pixels advance counters but assert no writes and no pool_valid. The final beat still triggers DONE.
- No in_valid: all strobes 0, addresses 0, mux_en 0, counters hold.
- Reset mid-pass: immediate return to IDLE. Partial reg-file contents are ignored by the next pass, because every window is seeded by a wr_ctrl1 beat.
- Simultaneous start and in_valid in IDLE: start accepted; the in_valid beat is not consumed (first consumed beat is next cycle).
- Counters: row/col are DIM_W bits; no overflow possible given the latched bounds.

Optional Feature:
- Macro: POOL_STALL_CNT_EN.
- Defined: stall_cnt counts RUN cycles with in_valid=0. It saturates at 0xFFFF, clears on accepted start, and holds after DONE.
- Undefined: no counter logic; stall_cnt tied to 0.

Test Plan:
- 4x4 map, start, 16 consecutive beats -> pool_valid on beats 6,8,14,16. adrs_out 0,1,0,1 on those beats. pool_done 1 cycle after beat 16. busy low after.
- 5x3 map -> wr_ctrl1 only on row0 cols 0,2. Col 4 and row 2 produce no strobes. Exactly 2 pool_valid. DONE after beat 15.
- fmap_w=40 with ADDR_W=4 -> cfg_err pulse, stays IDLE. fmap_h=1 -> cfg_err pulse.
- 4x4 map with in_valid toggling 1,0 -> same strobe sequence as the contiguous case. With POOL_STALL_CNT_EN: stall_cnt=15 at done.
- nrst low after 7 beats, then restart 4x4 -> outputs 0 during reset. Second pass matches the contiguous reference sequence.
- start asserted during RUN and in the DONE cycle -> ignored, no cfg_err, pass result unchanged.

Source files
------------

// File: rtl/pool_window_sequencer.sv
`timescale 1ns/1ps
// pool_window_sequencer
// Sequences one column of the 2x2 / stride-2 pooling datapath (register file
// plus max/average compare unit). Pixels arrive from the systolic array in
// raster order, one per in_valid beat; this block generates the register-file
// addresses and write strobes, the compare-unit input select and the
// pooled-output valid / pass-done flags for column 0.
//
// Optional feature macro: POOL_STALL_CNT_EN
//   defined   : stall_cnt counts RUN cycles without in_valid (saturating,
//               cleared on an accepted start, held after DONE)
//   undefined : stall_cnt is tied to 0
//
// Ports
//   clk, nrst          clock, asynchronous active-low reset
//   start              start a pass (sampled in IDLE only)
//   fmap_w, fmap_h     feature-map dimensions, latched on an accepted start
//   in_valid           systolic-array pixel valid
//   mux_en             compare-unit input taken from the systolic array
//   wr_ctrl1/adrs_in1  write raw pixel (window seed)
//   wr_ctrl2/adrs_in2  write partial pooled result
//   adrs_out           register-file read address
//   pool_valid         compare output is a final pooled value
//   pool_done          one-cycle pulse when the pass completes
//   busy               high in RUN and DONE
//   cfg_err            one-cycle pulse when a start is rejected
//   stall_cnt          idle-beat counter (see macro above)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | consuming pixel beats, row/col counters active
// DONE  | pass complete, pool_done asserted for this cycle
module pool_window_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [DIM_W-1:0]  fmap_w,
  input  logic [DIM_W-1:0]  fmap_h,
  input  logic              in_valid,
  output logic              mux_en,
  output logic              wr_ctrl1,
  output logic              wr_ctrl2,
  output logic [ADDR_W-1:0] adrs_in1,
  output logic [ADDR_W-1:0] adrs_in2,
  output logic [ADDR_W-1:0] adrs_out,
  output logic              pool_valid,
  output logic              pool_done,
  output logic              busy,
  output logic              cfg_err,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int               MAX_W   = 2 << ADDR_W;
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  state_t            state;
  logic [DIM_W-1:0]  row, col, w_lat, h_lat;
  logic              beat, last_col, last_row, drop, start_ok, start_acc;
  logic [ADDR_W-1:0] h;

  assign beat      = (state == RUN) && in_valid;
  assign last_col  = (col == w_lat - DIM_ONE);
  assign last_row  = (row == h_lat - DIM_ONE);
  // Trailing odd column / row has no partner pixel: floor semantics.
  assign drop      = (w_lat[0] && last_col) || (h_lat[0] && last_row);
  assign h         = col[ADDR_W:1];
  assign start_ok  = (32'(fmap_w) >= 32'd2) && (32'(fmap_w) <= 32'(MAX_W)) &&
                     (32'(fmap_h) >= 32'd2);
  assign start_acc = (state == IDLE) && start && start_ok;

  // Mealy decode so the register file writes on the same edge as the beat.
  always_comb begin
    mux_en     = 1'b0;
    wr_ctrl1   = 1'b0;
    wr_ctrl2   = 1'b0;
    adrs_in1   = '0;
    adrs_in2   = '0;
    adrs_out   = '0;
    pool_valid = 1'b0;
    if (beat && !drop) begin
      mux_en = 1'b1;
      unique case ({row[0], col[0]})
        2'b00: begin
          wr_ctrl1 = 1'b1;
          adrs_in1 = h;
        end
        2'b11: begin
          adrs_out   = h;
          pool_valid = 1'b1;
        end
        default: begin
          adrs_out = h;
          wr_ctrl2 = 1'b1;
          adrs_in2 = h;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      w_lat     <= '0;
      h_lat     <= '0;
      pool_done <= 1'b0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      pool_done <= 1'b0;
      cfg_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              w_lat <= fmap_w;
              h_lat <= fmap_h;
              row   <= '0;
              col   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                pool_done <= 1'b1;
                state     <= DONE;
              end else begin
                row <= row + DIM_ONE;
              end
            end else begin
              col <= col + DIM_ONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POOL_STALL_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && !in_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pool_window_sequencer.sv
`timescale 1ns/1ps
module tb_pool_window_sequencer;

  logic        clk = 1'b0;
  logic        nrst, start, in_valid;
  logic [7:0]  fmap_w, fmap_h;
  logic        mux_en, wr_ctrl1, wr_ctrl2, pool_valid, pool_done, busy, cfg_err;
  logic [3:0]  adrs_in1, adrs_in2, adrs_out;
  logic [15:0] stall_cnt;
  logic [15:0] strb;

  int n_checks = 0;
  int n_errors = 0;

  // {mux_en, wr_ctrl1, wr_ctrl2, pool_valid, adrs_in1, adrs_in2, adrs_out}
  logic [15:0] ref44 [16] = '{16'hC000, 16'hA000, 16'hC100, 16'hA011,
                              16'hA000, 16'h9000, 16'hA011, 16'h9001,
                              16'hC000, 16'hA000, 16'hC100, 16'hA011,
                              16'hA000, 16'h9000, 16'hA011, 16'h9001};
  logic [15:0] ref53 [15] = '{16'hC000, 16'hA000, 16'hC100, 16'hA011, 16'h0000,
                              16'hA000, 16'h9000, 16'hA011, 16'h9001, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

  pool_window_sequencer #(.ADDR_W(4), .DIM_W(8)) dut (
    .clk(clk), .nrst(nrst), .start(start), .fmap_w(fmap_w), .fmap_h(fmap_h),
    .in_valid(in_valid), .mux_en(mux_en), .wr_ctrl1(wr_ctrl1), .wr_ctrl2(wr_ctrl2),
    .adrs_in1(adrs_in1), .adrs_in2(adrs_in2), .adrs_out(adrs_out),
    .pool_valid(pool_valid), .pool_done(pool_done), .busy(busy),
    .cfg_err(cfg_err), .stall_cnt(stall_cnt)
  );

  assign strb = {mux_en, wr_ctrl1, wr_ctrl2, pool_valid, adrs_in1, adrs_in2, adrs_out};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel beat; outputs checked mid-cycle, consumed at the next edge.
  task automatic beat(input logic [15:0] exp, input string tag);
    in_valid = 1'b1;
    #4 check(tag, 32'(strb), 32'(exp));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic beat_nc();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    #4 check("gap_strobes", 32'(strb), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic start_pass(input logic [7:0] w, input logic [7:0] hh);
    start = 1'b1; fmap_w = w; fmap_h = hh;
    @(posedge clk); #1;
    start = 1'b0;
    #1 check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic check_done();
    #3 check("done_pulse", 32'({pool_done, busy}), 32'b11);
    @(posedge clk); #1;
    #3 check("done_to_idle", 32'({pool_done, busy, cfg_err}), 32'b000);
    @(posedge clk); #1;
  endtask

  task automatic reject(input logic [7:0] w, input logic [7:0] hh, input string tag);
    start = 1'b1; fmap_w = w; fmap_h = hh;
    @(posedge clk); #1;
    start = 1'b0;
    #3 check(tag, 32'({cfg_err, busy}), 32'b10);
    @(posedge clk); #1;
    #3 check("cfg_err_one_cycle", 32'({cfg_err, busy}), 32'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; in_valid = 1'b0; fmap_w = '0; fmap_h = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_strobes", 32'(strb), 32'd0);
    check("reset_flags", 32'({pool_done, busy, cfg_err}), 32'd0);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // 4x4 contiguous
    start_pass(8'd4, 8'd4);
    for (int i = 0; i < 16; i++) beat(ref44[i], "map4x4");
    check_done();
    check("stall_contig", 32'(stall_cnt), 32'd0);

    // 5x3 with in_valid coincident with start (that beat is not consumed)
    start = 1'b1; fmap_w = 8'd5; fmap_h = 8'd3; in_valid = 1'b1;
    #4 check("idle_beat_ignored", 32'(strb), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 15; i++) beat(ref53[i], "map5x3");
    check_done();

    // rejected starts
    reject(8'd40, 8'd4, "cfg_err_w40");
    reject(8'd4, 8'd1, "cfg_err_h1");
    reject(8'd1, 8'd4, "cfg_err_w1");
    reject(8'd33, 8'd2, "cfg_err_w33");

    // widest legal map, 32x2
    start_pass(8'd32, 8'd2);
    check("w32_no_err", 32'(cfg_err), 32'd0);
    for (int i = 0; i < 62; i++) beat_nc();
    beat(16'hA0FF, "w32_col30");
    beat(16'h900F, "w32_col31");
    check_done();

    // 4x4 with in_valid toggling
    start_pass(8'd4, 8'd4);
    for (int i = 0; i < 16; i++) begin
      beat(ref44[i], "map4x4_toggle");
      if (i < 15) gap();
    end
    check_done();
`ifdef POOL_STALL_CNT_EN
    check("stall_toggle", 32'(stall_cnt), 32'd15);
`else
    check("stall_toggle", 32'(stall_cnt), 32'd0);
`endif

    // reset mid-pass, then a clean restart
    start_pass(8'd4, 8'd4);
    check("stall_cleared", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 7; i++) beat(ref44[i], "pre_reset");
    nrst = 1'b0; in_valid = 1'b1;
    #3 check("reset_mid_strobes", 32'(strb), 32'd0);
    check("reset_mid_flags", 32'({pool_done, busy, cfg_err}), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start_pass(8'd4, 8'd4);
    for (int i = 0; i < 16; i++) beat(ref44[i], "post_reset");
    check_done();

    // start during RUN and in the DONE cycle is ignored
    start_pass(8'd4, 8'd4);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin start = 1'b1; fmap_w = 8'd40; end
      beat(ref44[i], "start_in_run");
      start = 1'b0;
      if (i == 5) check("no_cfg_err_run", 32'(cfg_err), 32'd0);
    end
    start = 1'b1; fmap_w = 8'd4; fmap_h = 8'd4;
    #3 check("done_with_start", 32'({pool_done, busy}), 32'b11);
    @(posedge clk); #1;
    start = 1'b0;
    #3 check("start_in_done_ignored", 32'({pool_done, busy, cfg_err}), 32'b000);
    @(posedge clk); #1;
    check("idle_after_ignored", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
